// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: opcode map, sequencer phases
// and the strobe bundle produced by the controller.
package cpu_pkg;

    localparam int OP_CODE_WIDTH = 3;
    localparam int ADDRESS_WIDTH = 5;

    localparam logic [2:0] HLT = 3'd0;
    localparam logic [2:0] SKZ = 3'd1;
    localparam logic [2:0] ADD = 3'd2;
    localparam logic [2:0] AND = 3'd3;
    localparam logic [2:0] XOR = 3'd4;
    localparam logic [2:0] LDA = 3'd5;
    localparam logic [2:0] STO = 3'd6;
    localparam logic [2:0] JMP = 3'd7;

    localparam logic [2:0] INST_ADDR  = 3'd0;
    localparam logic [2:0] INST_FETCH = 3'd1;
    localparam logic [2:0] INST_LOAD  = 3'd2;
    localparam logic [2:0] IDLE       = 3'd3;
    localparam logic [2:0] OP_ADDR    = 3'd4;
    localparam logic [2:0] OP_FETCH   = 3'd5;
    localparam logic [2:0] ALU_OP     = 3'd6;
    localparam logic [2:0] STORE      = 3'd7;

    typedef enum logic {
        RUNNING = 1'b0,
        HALTED  = 1'b1
    } run_state_t;

    typedef struct packed {
        logic sel;
        logic rd;
        logic wr;
        logic ld_ir;
        logic inc_pc;
        logic ld_pc;
        logic ld_ac;
        logic data_e;
        logic halt;
    } ctrl_t;

    // Instructions that read an operand from memory into the accumulator.
    function automatic logic is_alu_op(input logic [2:0] op);
        return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    endfunction

endpackage

// File: rtl/cpu_phase_counter.sv
// Free-running 3-bit phase counter with hold and asynchronous clear;
// shared by the controller and the clock generator.
module cpu_phase_counter (
    input  logic       clk,
    input  logic       clr,
    input  logic       hold,
    output logic [2:0] count
);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            count <= 3'd0;
        end else if (!hold) begin
            count <= count + 3'd1;
        end
    end

endmodule

// File: rtl/cpu_controller.sv
// Eight-phase instruction sequencer: decodes phase, opcode and the zero flag
// into the datapath strobes, and freezes at OP_ADDR once a HLT executes.
module cpu_controller
    import cpu_pkg::*;
#(
    parameter int OP_CODE_WIDTH = cpu_pkg::OP_CODE_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [OP_CODE_WIDTH-1:0] op_code,
    input  logic                     zero,
    output logic                     sel,
    output logic                     rd,
    output logic                     wr,
    output logic                     ld_ir,
    output logic                     inc_pc,
    output logic                     ld_pc,
    output logic                     ld_ac,
    output logic                     data_e,
    output logic                     halt,
    output logic [2:0]               phase
);

    if (OP_CODE_WIDTH != 3) begin : g_bad_op_code_width
        $error("cpu_controller: OP_CODE_WIDTH must be 3");
    end

    run_state_t state;
    run_state_t state_next;
    ctrl_t      ctrl;
    logic       alu_op;

    assign alu_op = is_alu_op(op_code);

    cpu_phase_counter u_phase_counter (
        .clk   (clk),
        .clr   (rst),
        .hold  (state_next == HALTED),
        .count (phase)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUNNING;
        end else begin
            state <= state_next;
        end
    end

    // Halting happens on the edge leaving OP_ADDR; the counter holds in the same edge.
    always_comb begin
        state_next = state;
        if (state == RUNNING && phase == OP_ADDR && op_code == HLT) begin
            state_next = HALTED;
        end
    end

    always_comb begin
        ctrl = '0;
        if (state == HALTED) begin
            ctrl.halt = 1'b1;
        end else begin
            case (phase)
                INST_ADDR: begin
                    ctrl.sel = 1'b1;
                end
                INST_FETCH: begin
                    ctrl.sel = 1'b1;
                    ctrl.rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    ctrl.sel   = 1'b1;
                    ctrl.rd    = 1'b1;
                    ctrl.ld_ir = 1'b1;
                end
                OP_ADDR: begin
                    ctrl.inc_pc = 1'b1;
                    ctrl.halt   = (op_code == HLT);
                end
                OP_FETCH: begin
                    ctrl.rd = alu_op;
                end
                ALU_OP: begin
                    ctrl.rd     = alu_op;
                    ctrl.inc_pc = (op_code == SKZ) && zero;
                    ctrl.ld_pc  = (op_code == JMP);
                    ctrl.data_e = (op_code == STO);
                end
                STORE: begin
                    ctrl.rd     = alu_op;
                    ctrl.ld_ac  = alu_op;
                    ctrl.ld_pc  = (op_code == JMP);
                    ctrl.wr     = (op_code == STO);
                    ctrl.data_e = (op_code == STO);
                end
                default: begin
                    ctrl = '0;
                end
            endcase
        end
    end

    assign sel    = ctrl.sel;
    assign rd     = ctrl.rd;
    assign wr     = ctrl.wr;
    assign ld_ir  = ctrl.ld_ir;
    assign inc_pc = ctrl.inc_pc;
    assign ld_pc  = ctrl.ld_pc;
    assign ld_ac  = ctrl.ld_ac;
    assign data_e = ctrl.data_e;
    assign halt   = ctrl.halt;

endmodule

// File: doc/cpu_controller.md
Name: cpu_controller

Overview:
- Phase sequencer for the 8-bit accumulator RISC CPU.
- Consumes the instruction register's op_code plus the ALU zero flag.
- Generates every datapath strobe: memory select/read/write, ld_ir, PC increment/load, accumulator load, data bus enable, halt.
- Sits on the opposite end of the IR interface: it drives ld_ir and acts on the op_code the IR returns.

Parameters:
OP_CODE_WIDTH, 3, width of op_code input; the opcode map below requires 3.

Ports:
clk  in  1  system clock, rising-edge.
rst  in  1  asynchronous, active-high reset.
op_code  in  OP_CODE_WIDTH  current opcode from the instruction register.
zero  in  1  accumulator-is-zero flag from the ALU.
sel  out  1  1 = memory address from PC, 0 = from IR address field.
rd  out  1  memory read enable.
wr  out  1  memory write strobe.
ld_ir  out  1  instruction register load.
inc_pc  out  1  program counter increment.
ld_pc  out  1  program counter load (jump).
ld_ac  out  1  accumulator load.
data_e  out  1  accumulator drives data bus.
halt  out  1  CPU halted indicator.
phase  out  3  current phase, for debug and verification.

Behaviour:
- Opcode map:
  - HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
  - ALUOP = ADD | AND | XOR | LDA.
- State: 3-bit phase counter 0..7 plus 1-bit halted flag.
- Phase counter:
  - Increments each clk while not halted.
  - Wraps 7 -> 0 on the next clk.
  - One instruction = 8 clocks.
- Reset (async, active-high):
  - phase=0, halted=0 immediately on rst assertion, independent of clk.
  - Outputs therefore immediately take their phase-0 values: sel=1, all others 0, phase=0.
  - Reset mid-instruction abandons that instruction; no wr or ld_pc may pulse while rst is high.
- Outputs are combinational Moore-style decode of (phase, op_code, zero, halted). Latency is zero from phase.
  - Phase 0 INST_ADDR: sel=1.
  - Phase 1 INST_FETCH: sel=1, rd=1.
  - Phase 2 INST_LOAD: sel=1, rd=1, ld_ir=1.
  - Phase 3 IDLE: sel=1, rd=1, ld_ir=1.
  - Phase 4 OP_ADDR: inc_pc=1; halt=1 if op_code==HLT.
  - Phase 5 OP_FETCH: rd=ALUOP.
  - Phase 6 ALU_OP: rd=ALUOP; inc_pc=(SKZ & zero); ld_pc=JMP; data_e=STO.
  - Phase 7 STORE: rd=ALUOP; ld_ac=ALUOP; ld_pc=JMP; wr=STO; data_e=STO.
  - Any output not listed for a phase is 0.
- op_code is sampled only from phase 4 onward. Its value during phases 0-3 must not affect any output except through the phase-4..7 decode.
- Halt:
  - At the phase 4 -> 5 clock edge with op_code==HLT, set halted=1 and hold phase at 4. No wrap occurs.
  - While halted: phase stays 4, halt=1, inc_pc=0, all other outputs 0.
  - Exit only via rst.
  - The single inc_pc pulse in the un-halted phase 4 before halting is retained, so the PC points past the HLT.
- SKZ with zero=0: no extra increment. zero is sampled combinationally in phase 6 only.
- JMP asserts ld_pc in both phases 6 and 7. The PC must tolerate the double load, since the address is stable.
- Reserved: op_code width other than 3 is a compile-time error (elaboration assertion).

Decomposition:
- Shared package cpu_pkg:
  - Opcode localparams HLT..JMP.
  - Phase localparams INST_ADDR..STORE.
  - OP_CODE_WIDTH / ADDRESS_WIDTH defaults shared with the instruction register.
- One natural sub-module: cpu_phase_counter.
  - 3-bit wrapping counter with hold input and async active-high clear.
  - Also reused by the clock generator.
- Output decode stays in cpu_controller as a single combinational case on phase.

Test Plan:
- Reset: assert rst mid-phase 5 with op_code=STO.
  - -> phase=0, sel=1, wr=0, data_e=0 immediately, without waiting for clk.
  - -> after release, phases 0..7 in successive clocks.
- ADD sequence: op_code=2, zero=0, run 8 clocks from phase 0.
  - -> ld_ir high in phases 2-3 only.
  - -> inc_pc in phase 4 only.
  - -> rd in 1,2,3,5,6,7.
  - -> ld_ac in 7 only; wr never.
- STO: op_code=6.
  - -> data_e=1 in phases 6-7; wr=1 in phase 7 only.
  - -> rd=0 and ld_ac=0 in phases 5-7.
- SKZ: op_code=1.
  - -> with zero=1: inc_pc=1 in phases 4 and 6 (2 pulses).
  - -> with zero=0: inc_pc=1 in phase 4 only.
- JMP: op_code=7.
  - -> ld_pc=1 in phases 6 and 7.
  - -> inc_pc only in phase 4; rd=0 in phases 5-7.
- HLT: op_code=0.
  - -> halt=1 in phase 4.
  - -> phase stays 4 for 20 further clocks with all strobes 0, even if op_code changes to ADD.
  - -> rst pulse returns phase=0, halt=0.
